// File: rtl/jac_alu_pkg.sv
// rtl/jac_alu_pkg.sv - shared widths, opcodes, status bits and FSM states for the Jac1-8 ALU sequencer
package jac_alu_pkg;

  localparam int DataWidth     = 8;
  localparam int NumOpCodeBits = 5;
  localparam int ParamBits     = 8;
  localparam int NumStatusBits = 3;
  localparam int NumRegs       = 8;
  localparam int RegAddrBits   = 3;

  localparam int STAT_OVF  = 0;
  localparam int STAT_UNF  = 1;
  localparam int STAT_ZERO = 2;

  localparam logic [NumOpCodeBits-1:0] Op_NOP = 5'b0_0000;
  localparam logic [NumOpCodeBits-1:0] Op_ADD = 5'b0_0001;
  localparam logic [NumOpCodeBits-1:0] Op_SUB = 5'b0_0010;
  localparam logic [NumOpCodeBits-1:0] Op_AND = 5'b0_0011;
  localparam logic [NumOpCodeBits-1:0] Op_OR  = 5'b0_0100;
  localparam logic [NumOpCodeBits-1:0] Op_XOR = 5'b0_0101;
  localparam logic [NumOpCodeBits-1:0] Op_NOT = 5'b0_0110;
  localparam logic [NumOpCodeBits-1:0] Op_SHL = 5'b0_0111;
  localparam logic [NumOpCodeBits-1:0] Op_SHR = 5'b0_1000;
  localparam logic [NumOpCodeBits-1:0] Op_VAL = 5'b0_1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  function automatic logic is_legal_op(input logic [NumOpCodeBits-1:0] op);
    return op <= Op_VAL;
  endfunction

endpackage

// File: rtl/jac_regfile.sv
// rtl/jac_regfile.sv - 8x8 register file, two operand reads plus debug read, writeback beats direct load
module jac_regfile
  import jac_alu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_en_i,
  input  logic [RegAddrBits-1:0] wb_addr_i,
  input  logic [DataWidth-1:0]   wb_data_i,
  input  logic                   ld_en_i,
  input  logic [RegAddrBits-1:0] ld_addr_i,
  input  logic [DataWidth-1:0]   ld_data_i,
  input  logic [RegAddrBits-1:0] rd1_addr_i,
  output logic [DataWidth-1:0]   rd1_data_o,
  input  logic [RegAddrBits-1:0] rd2_addr_i,
  output logic [DataWidth-1:0]   rd2_data_o,
  input  logic [RegAddrBits-1:0] dbg_addr_i,
  output logic [DataWidth-1:0]   dbg_data_o
);

  logic [DataWidth-1:0] regs_q [NumRegs];

  // Writeback is assigned last so it overrides a same-address load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (ld_en_i) regs_q[ld_addr_i] <= ld_data_i;
      if (wb_en_i) regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign rd1_data_o = regs_q[rd1_addr_i];
  assign rd2_data_o = regs_q[rd2_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state issue controller driving the external ALU_J with regfile writeback
module alu_sequencer
  import jac_alu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [NumOpCodeBits-1:0] instr_opcode,
  input  logic [RegAddrBits-1:0]   instr_dst,
  input  logic [RegAddrBits-1:0]   instr_src1,
  input  logic [RegAddrBits-1:0]   instr_src2,
  input  logic [ParamBits-1:0]     instr_param,
  input  logic                     ld_en,
  input  logic [RegAddrBits-1:0]   ld_addr,
  input  logic [DataWidth-1:0]     ld_data,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [NumStatusBits-1:0] flags,
  output logic                     done,
  output logic                     illegal,
  input  logic [RegAddrBits-1:0]   dbg_addr,
  output logic [DataWidth-1:0]     dbg_data
);

  state_e                   state_q, state_d;
  logic [NumOpCodeBits-1:0] op_q;
  logic [RegAddrBits-1:0]   dst_q, src1_q, src2_q;
  logic [ParamBits-1:0]     param_q;
  logic [NumOpCodeBits-1:0] alu_opcode_q;
  logic [DataWidth-1:0]     operand1_q, operand2_q;
  logic [ParamBits-1:0]     alu_param_q;
  logic [DataWidth-1:0]     result_q;
  logic [NumStatusBits-1:0] status_q;
  logic [NumStatusBits-1:0] flags_q;
  logic [DataWidth-1:0]     rd1_data, rd2_data;
  logic                     op_legal;
  logic                     wb_write;

  assign op_legal = is_legal_op(op_q);

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    wb_write    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_READ;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        done     = 1'b1;
        illegal  = !op_legal;
        wb_write = op_legal && (op_q != Op_NOP);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= Op_NOP;
      dst_q        <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      param_q      <= '0;
      alu_opcode_q <= Op_NOP;
      operand1_q   <= '0;
      operand2_q   <= '0;
      alu_param_q  <= '0;
      result_q     <= '0;
      status_q     <= '0;
      flags_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q    <= instr_opcode;
            dst_q   <= instr_dst;
            src1_q  <= instr_src1;
            src2_q  <= instr_src2;
            param_q <= instr_param;
          end
        end
        ST_READ: begin
          // Undefined opcodes are presented to the ALU as NOP.
          alu_opcode_q <= op_legal ? op_q : Op_NOP;
          operand1_q   <= rd1_data;
          operand2_q   <= rd2_data;
          alu_param_q  <= param_q;
        end
        ST_EXEC: begin
          result_q <= alu_result;
          status_q <= alu_status;
        end
        ST_WB: begin
          alu_opcode_q <= Op_NOP;
          if (wb_write) flags_q <= status_q;
        end
        default: ;
      endcase
    end
  end

  jac_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_en_i    (wb_write),
    .wb_addr_i  (dst_q),
    .wb_data_i  (result_q),
    .ld_en_i    (ld_en),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .rd1_addr_i (src1_q),
    .rd1_data_o (rd1_data),
    .rd2_addr_i (src2_q),
    .rd2_data_o (rd2_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign alu_opcode   = alu_opcode_q;
  assign alu_operand1 = operand1_q;
  assign alu_operand2 = operand2_q;
  assign alu_param    = alu_param_q;
  assign flags        = flags_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle issue controller that sequences the 8-bit ALU (ALU_J) for the Jac1-8 core. It accepts one register-to-register instruction at a time through a valid/ready handshake, reads operands from an internal 8-entry register file, and drives the external combinational ALU. It then writes the result back and latches the 3-bit status into a flags register for the branch logic.

Parameters:
DataWidth, 8, register/operand/result width
NumOpCodeBits, 5, ALU opcode width
ParamBits, 8, ALU param width
NumStatusBits, 3, ALU status width (bit0 overflow, bit1 underflow, bit2 zero)
NumRegs, 8, register file depth
RegAddrBits, 3, register address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept; high only in IDLE
instr_opcode  in  5  ALU opcode
instr_dst  in  3  destination register
instr_src1  in  3  operand1 register
instr_src2  in  3  operand2 register
instr_param  in  8  passed unchanged to the ALU param input
ld_en  in  1  direct register load strobe
ld_addr  in  3  load address
ld_data  in  8  load data
alu_opcode  out  5  to ALU opcode
alu_operand1  out  8  to ALU operand1
alu_operand2  out  8  to ALU operand2
alu_param  out  8  to ALU param
alu_result  in  8  from ALU result
alu_status  in  3  from ALU status
flags  out  3  latched status of last writing instruction
done  out  1  one-cycle pulse at retirement
illegal  out  1  one-cycle pulse, retired opcode greater than 5'b0_1001
dbg_addr  in  3  combinational debug read address
dbg_data  out  8  regfile[dbg_addr], combinational

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all registers, flags, alu_* outputs = 0 (alu_opcode = NOP 5'b0_0000).
  - done=0, illegal=0.
  - Reset mid-instruction aborts it: no writeback, no done.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE. instr_ready = (state==IDLE), purely combinational from state.
- IDLE: on instr_valid && instr_ready at edge T0, capture opcode/dst/src1/src2/param into the instruction latch and go to READ.
- READ (cycle T0+1): at its closing edge, register alu_operand1=reg[src1], alu_operand2=reg[src2], alu_opcode, alu_param.
- EXEC (T0+2): ALU inputs stable for the full cycle; at the closing edge, capture alu_result/alu_status into internal result/status registers.
- WB (T0+3): done=1 this cycle; at the closing edge, write reg[dst] and flags.
  - alu_opcode returns to NOP; alu_operand*/param hold their values.
- Fixed latency: 4 cycles from accept to done; maximum throughput one instruction per 4 cycles.
- NOP: runs through all states; no register write; flags unchanged; done pulses.
- Opcodes 0_1010..1_1111: treated as NOP (alu_opcode driven NOP); illegal pulses together with done.
- flags are updated only by a writing instruction and mirror alu_status exactly, including 0 (flags are cleared when no status bit is set).
- src1==src2 or dst==srcN is legal: operands are read in READ, so the write in WB sees no hazard.
- Register file read is combinational in READ, so an ld_en write at READ's closing edge is not seen by that instruction.
- ld_en is accepted in any state and writes at the edge.
- ld_en in the WB cycle to the same address as dst: writeback wins.
- instr_valid held while busy is ignored; there is no queueing.

Decomposition:
- Package jac_alu_pkg:
  - Op_NOP..Op_VAL opcode constants.
  - Width constants.
  - Status bit indices (STAT_OVF=0, STAT_UNF=1, STAT_ZERO=2).
  - FSM state encoding.
- Sub-module jac_regfile: 8x8 storage, async reset, 2 combinational read ports plus debug read, 2 write ports (wb priority over ld).
- The ALU is instantiated at the top level, not inside this block.

Test Plan:
- Load r1=255, r2=2; issue ADD r3,r1,r2 -> done at accept+4 cycles; r3=1; flags=3'b001.
- Load r4=14, r5=15; issue SUB r6,r4,r5 -> r6=255; flags=3'b010. Then AND r7,(0xCC),(0x33) -> r7=0; flags=3'b100.
- Hold instr_valid high with two back-to-back ADDs -> second accepted exactly 4 cycles after first; instr_ready low during READ/EXEC/WB.
- After flags=3'b100, issue NOP then opcode 5'b1_0000 -> no register change; flags stay 3'b100; illegal pulses only on the second instruction.
- Assert rst_n low during EXEC of ADD r3 (r3 previously 9) -> r3=0, flags=0, no done, instr_ready=1 after release.
- ld_en r3=0x55 in the WB cycle of an ADD writing r3=4 -> r3=4. An ld_en to src1 during READ -> operand uses the old value.
